// File: rtl/fma_wb_buffer.sv
// Writeback result buffer behind a fused multiply-add pipe: credit-tracked FIFO with a registered head.
// Optional exception-flag accumulator is enabled by defining FMA_WB_FFLAGS_EN.
module fma_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_fire,
    output logic             can_issue,
    input  logic             in_valid,
    input  logic [64:0]      in_data,
    input  logic [4:0]       in_exc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64:0]      out_data,
    output logic [4:0]       out_exc,
    output logic [TAG_W-1:0] out_tag,
    output logic             overflow_err,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = PTR_W + 2;
    localparam int ENT_W = 65 + 5 + TAG_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [INF_W-1:0] inflight_reg, inflight_next;
    logic             overflow_reg, overflow_next;
    logic [ENT_W-1:0] head_reg, head_next;
    logic [ENT_W-1:0] in_entry;
    logic [INF_W:0]   credit_sum;
    logic             deq, enq, full, drop;

    assign in_entry = {in_data, in_exc, in_tag};

    always_comb begin
        deq        = (count_reg != '0) && out_ready;
        full       = (count_reg == CNT_W'(DEPTH));
        enq        = in_valid && (!full || deq);
        drop       = in_valid && full && !deq;

        rd_ptr_next = deq ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        wr_ptr_next = enq ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;

        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        inflight_next = inflight_reg;
        case ({issue_fire, in_valid})
            2'b10: if (inflight_reg != '1) inflight_next = inflight_reg + INF_W'(1);
            2'b01: if (inflight_reg != '0) inflight_next = inflight_reg - INF_W'(1);
            default: inflight_next = inflight_reg;
        endcase

        overflow_next = overflow_reg | drop;

        // The head register is preloaded one cycle ahead; when the buffer is (or drains to)
        // empty this cycle, the only candidate for the next head is the arriving result.
        head_next = '0;
        if (count_next == '0)
            head_next = '0;
        else if ((count_reg - CNT_W'(deq)) == '0)
            head_next = in_entry;
        else
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clock) begin
        if (enq && !reset)
            mem[wr_ptr_reg] <= in_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            overflow_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            overflow_reg <= overflow_next;
            head_reg     <= head_next;
        end
    end

    assign credit_sum   = (INF_W+1)'(count_reg) + (INF_W+1)'(inflight_reg);
    assign can_issue    = credit_sum < (INF_W+1)'(DEPTH);
    assign out_valid    = (count_reg != '0);
    assign out_data     = head_reg[ENT_W-1 -: 65];
    assign out_exc      = head_reg[TAG_W +: 5];
    assign out_tag      = head_reg[TAG_W-1:0];
    assign overflow_err = overflow_reg;

`ifdef FMA_WB_FFLAGS_EN
    logic [4:0] fflags_reg;

    // A clear coinciding with a dequeue keeps only that dequeue's flags.
    always_ff @(posedge clock) begin
        if (reset)
            fflags_reg <= '0;
        else if (fflags_clr)
            fflags_reg <= deq ? out_exc : 5'b0;
        else if (deq)
            fflags_reg <= fflags_reg | out_exc;
    end

    assign fflags = fflags_reg;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags = 5'b0;
`endif

endmodule

// File: tb/tb_fma_wb_buffer.sv
// Directed self-checking bench for fma_wb_buffer (DEPTH=4, TAG_W=5); honours FMA_WB_FFLAGS_EN.
module tb_fma_wb_buffer;

`ifdef FMA_WB_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, issue_fire, can_issue, in_valid, out_valid, out_ready;
    logic [64:0] in_data, out_data;
    logic [4:0]  in_exc, out_exc, in_tag, out_tag, fflags;
    logic        overflow_err, fflags_clr;

    int total  = 0;
    int passed = 0;

    fma_wb_buffer #(.DEPTH(4), .TAG_W(5)) dut (
        .clock(clock), .reset(reset), .issue_fire(issue_fire), .can_issue(can_issue),
        .in_valid(in_valid), .in_data(in_data), .in_exc(in_exc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_tag(out_tag), .overflow_err(overflow_err),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s: observed %0h expected %0h ok", name, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [64:0] dat(input int t);
        logic [64:0] v;
        v = 65'h1_0000_0000_0000_0000 | 65'(t) | (65'(t) << 32);
        return v;
    endfunction

    task automatic put(input int t, input logic [4:0] e);
        in_valid = 1'b1;
        in_data  = dat(t);
        in_exc   = e;
        in_tag   = 5'(t);
    endtask

    initial begin
        reset = 1'b1; issue_fire = 1'b0; in_valid = 1'b0; in_data = '0; in_exc = '0;
        in_tag = '0; out_ready = 1'b0; fflags_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_exc", out_exc, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_can_issue", can_issue, 1);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_fflags", fflags, 0);

        // single result
        issue_fire = 1'b1; tick(); issue_fire = 1'b0;
        chk("single_can_issue", can_issue, 1);
        in_valid = 1'b1; in_data = 65'h1_0000_0000_0000_0001; in_exc = 5'b00001; in_tag = 5'd7;
        tick(); in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 65'h1_0000_0000_0000_0001);
        chk("single_exc", out_exc, 5'b00001);
        chk("single_tag", out_tag, 7);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("single_drained", out_valid, 0);
        chk("single_empty_data", out_data, 0);
        chk("single_fflags", fflags, FF_EN ? 5'b00001 : 5'b0);

        // credits
        issue_fire = 1'b1;
        tick(); tick(); tick();
        chk("credit_3", can_issue, 1);
        tick();
        issue_fire = 1'b0;
        chk("credit_4", can_issue, 0);
        for (int t = 10; t < 14; t++) begin
            put(t, 5'b0); tick();
        end
        in_valid = 1'b0;
        chk("credit_full", can_issue, 0);
        chk("full_head_tag", out_tag, 10);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("credit_return", can_issue, 1);
        chk("deq_head_tag", out_tag, 11);
        put(14, 5'b0); tick(); in_valid = 1'b0;
        chk("refull_credit", can_issue, 0);

        // simultaneous enqueue/dequeue at full
        put(15, 5'b10000); out_ready = 1'b1; tick(); in_valid = 1'b0; out_ready = 1'b0;
        chk("simul_head_tag", out_tag, 12);
        chk("simul_overflow", overflow_err, 0);
        chk("simul_still_full", can_issue, 0);

        // overflow drop
        put(16, 5'b01000); tick(); in_valid = 1'b0;
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_hold_tag", out_tag, 12);
        chk("ovf_hold_data", out_data, dat(12));
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_tag", out_tag, 5'(12 + j));
            chk("drain_data", out_data, dat(12 + j));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_empty_tag", out_tag, 0);
        chk("ovf_sticky", overflow_err, 1);
        chk("drain_credit", can_issue, 1);
        chk("drain_fflags", fflags, FF_EN ? 5'b10001 : 5'b0);
        fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
        chk("clr_fflags", fflags, 0);

        // pointer wrap, back-to-back
        reset = 1'b1; tick(); reset = 1'b0;
        chk("wrap_rst_overflow", overflow_err, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            put(k, (k == 1) ? 5'b00010 : ((k == 2) ? 5'b00100 : 5'b0));
            fflags_clr = (k == 3);
            tick();
            chk("wrap_valid", out_valid, 1);
            chk("wrap_tag", out_tag, 5'(k));
            if (k == 2) chk("wrap_fflags_acc", fflags, FF_EN ? 5'b00010 : 5'b0);
            if (k == 3) chk("wrap_fflags_clr_deq", fflags, FF_EN ? 5'b00100 : 5'b0);
        end
        in_valid = 1'b0; fflags_clr = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("wrap_empty", out_valid, 0);

        // reset mid-stream
        issue_fire = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        issue_fire = 1'b0;
        for (int t = 20; t < 23; t++) begin
            put(t, 5'b0); tick();
        end
        in_valid = 1'b0;
        chk("mid_can_issue", can_issue, 0);
        chk("mid_head_tag", out_tag, 20);
        reset = 1'b1; put(23, 5'b0); tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_tag", out_tag, 0);
        chk("mid_rst_can_issue", can_issue, 1);
        tick();
        chk("mid_rst_still_empty", out_valid, 0);
        put(24, 5'b0); tick(); in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_tag", out_tag, 24);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("post_rst_no_stale", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fma_wb_buffer.md
FMA_WB_BUFFER -- requirements
Module: fma_wb_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries (power of two, 2..16).
REQ-002 Parameter: TAG_W, 5, destination-register tag width.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: issue_fire  input  1  one operation issued into the upstream fused multiply-add pipeline this cycle.
REQ-006 Port: can_issue  output  1  a free entry is guaranteed for one more issued operation.
REQ-007 Port: in_valid  input  1  FMA pipe result valid (validout of the pipe).
REQ-008 Port: in_data  input  65  recoded double-precision result.
REQ-009 Port: in_exc  input  5  exception flags {NV,DZ,OF,UF,NX}.
REQ-010 Port: in_tag  input  TAG_W  destination tag delayed alongside the pipe.
REQ-011 Port: out_valid / out_ready  output / input  1 / 1  writeback handshake.
REQ-012 Port: out_data / out_exc / out_tag  output  65 / 5 / TAG_W  head-entry payload.
REQ-013 Port: overflow_err  output  1  sticky: result arrived with no room.
REQ-014 Port: fflags / fflags_clr  output / input  5 / 1  accumulated exception flags and their clear.

Function
REQ-015 Storage: circular FIFO of DEPTH entries {data, exc, tag}; read/write pointers wrap modulo DEPTH; count register holds 0..DEPTH.
REQ-016 Enqueue: when in_valid is 1 and (count<DEPTH or dequeue occurs the same cycle); no backpressure exists toward the pipe.
REQ-017 Dequeue: when out_valid and out_ready are both 1; out_valid = (count!=0); outputs come from registered storage only, so there is no same-cycle bypass and empty-to-out_valid latency is 1 cycle.
REQ-018 Simultaneous enqueue and dequeue: count unchanged; legal at count=DEPTH and at count=1.
REQ-019 In-flight counter: +1 on issue_fire, -1 on in_valid, net 0 when both occur; saturates at 0 and never underflows.
REQ-020 Credit rule: can_issue = (count + inflight) < DEPTH, computed combinationally from registered state.
REQ-021 Full-drop behaviour: in_valid with count=DEPTH and no dequeue drops the result, leaves storage unchanged, and sets overflow_err.
REQ-022 overflow_err remains set until reset.
REQ-023 Payload under no handshake: out_data, out_exc and out_tag hold stable while out_valid=1 and out_ready=0.
REQ-024 Payload when empty: out_data, out_exc and out_tag are all-zero whenever out_valid=0.

Reset
REQ-025 Reset clears pointers, count, inflight, overflow_err and fflags; afterwards out_valid=0, out_data/out_exc/out_tag=0, can_issue=1.
REQ-026 Reset asserted mid-operation discards all stored and in-flight results; in_valid in the reset cycle is ignored.
REQ-027 Storage array contents are not reset.

Configuration
REQ-028 Macro FMA_WB_FFLAGS_EN: when defined, fflags |= out_exc on each dequeue.
REQ-029 With FMA_WB_FFLAGS_EN defined, fflags_clr=1 zeroes fflags; a dequeue in the same cycle loads fflags with that dequeue's out_exc.
REQ-030 With FMA_WB_FFLAGS_EN undefined, fflags is tied to 0, fflags_clr is ignored, and no accumulator register exists.

Verification
REQ-031 Single result: reset, then issue_fire one cycle, then in_valid with data=65'h1_0000_0000_0000_0001, exc=5'b00001, tag=7 -> out_valid=1 the next cycle with the same payload; with out_ready=1 the entry dequeues and fflags=5'b00001 when FMA_WB_FFLAGS_EN is defined.
REQ-032 Credits: four issue_fire pulses with DEPTH=4 and no in_valid -> can_issue=0 after the fourth pulse and returns to 1 one cycle after the first dequeue.
REQ-033 Full plus simultaneous events: four entries stored, then in_valid together with out_ready=1 -> count stays 4, order is preserved, overflow_err=0.
REQ-034 Overflow: four entries stored and out_ready=0, then a fifth in_valid -> overflow_err=1, storage unchanged, and the next four dequeues return the first four payloads.
REQ-035 Pointer wrap: ten results enqueued and dequeued back-to-back with tags 0..9 -> tags emerge in order 0..9 with no gaps.
REQ-036 Reset mid-stream: three entries stored and inflight=2, then reset -> out_valid=0, can_issue=1, and stale entries never appear.
